// File: rtl/sec_fir_param.sv
// Time-multiplexed FIR filter with one multiply-accumulate per clock over a circular delay line.
// Optional features: symmetric-coefficient folding, round-half-up, and output saturation.
module sec_fir_param #(
    parameter int Win      = 16,
    parameter int Wc       = 18,
    parameter int Num_coef = 17,
    parameter int Wout     = 19,
    parameter int SYM      = 0,
    parameter int RND      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        val_in,
    input  logic signed [Win-1:0]       din,
    input  logic                        coef_we,
    input  logic [$clog2(Num_coef)-1:0] coef_addr,
    input  logic signed [Wc-1:0]        coef_din,
    output logic signed [Wout-1:0]      dout,
    output logic                        val_out,
    output logic                        busy,
    output logic                        overrun
);
    localparam int PW = $clog2(Num_coef);
    localparam int SB = (SYM != 0) ? 1 : 0;
    localparam int M  = (SYM != 0) ? (Num_coef + 1) / 2 : Num_coef;
    localparam int WF = Win + Wc;
    localparam int WX = Win + SB;
    localparam int WP = WX + Wc;
    localparam int WA = WF + PW + SB;
    localparam int SH = WF - Wout;
    localparam logic signed [WA-1:0] RND_ADD =
        (RND != 0 && SH > 0) ? (WA'(1) <<< ((SH > 0) ? SH - 1 : 0)) : '0;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t               state, state_nxt;
    logic signed [Win-1:0] x_mem [Num_coef];
    logic signed [Wc-1:0]  h_mem [Num_coef];
    logic [PW-1:0]         wr_ptr, rd_a, rd_b, cnt;
    logic signed [WA-1:0]  acc, acc_rnd;
    logic signed [WX-1:0]  tap;
    logic signed [WP-1:0]  prod;
    logic signed [Wout-1:0] dout_nxt;
    logic                  accept, pair, coef_ok, sat_pos, sat_neg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Num_coef - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(Num_coef - 1) : p - PW'(1);
    endfunction

    assign busy    = (state != IDLE);
    assign accept  = (state == IDLE) && val_in;
    assign coef_ok = (int'(coef_addr) < M);

    always_comb begin
        // NOTE: defaults first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (val_in) state_nxt = MAC;
            MAC:     if (cnt == PW'(M - 1)) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rd_a walks back from the newest sample, rd_b forward from the oldest; they meet at the middle tap.
    always_comb begin
        pair = (SYM != 0) && (rd_a != rd_b);
        tap  = WX'(x_mem[rd_a]);
        if (pair) tap = WX'(x_mem[rd_a]) + WX'(x_mem[rd_b]);
    end

    assign prod = WP'(tap) * WP'(h_mem[cnt]);

    assign acc_rnd = acc + RND_ADD;
    assign sat_pos = !acc_rnd[WA-1] && (|acc_rnd[WA-2:WF-1]);
    assign sat_neg = acc_rnd[WA-1] && !(&acc_rnd[WA-2:WF-1]);

    always_comb begin
        dout_nxt = Wout'(acc_rnd >>> SH);
        if (sat_pos)      dout_nxt = {1'b0, {(Wout-1){1'b1}}};
        else if (sat_neg) dout_nxt = {1'b1, {(Wout-1){1'b0}}};
    end

    // NOTE: delay line and coefficients are plain registers, so the async reset can clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Num_coef; i++) begin
                x_mem[i] <= '0;
                h_mem[i] <= '0;
            end
        end else begin
            if (accept) x_mem[wr_ptr] <= din;
            if (coef_we && !busy && coef_ok) h_mem[coef_addr] <= coef_din;
        end
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_a    <= '0;
            rd_b    <= '0;
            cnt     <= '0;
            acc     <= '0;
            dout    <= '0;
            val_out <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            val_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (val_in) begin
                        wr_ptr <= ptr_inc(wr_ptr);
                        rd_a   <= wr_ptr;
                        rd_b   <= ptr_inc(wr_ptr);
                        cnt    <= '0;
                        acc    <= '0;
                    end
                end
                MAC: begin
                    acc  <= acc + WA'(prod);
                    rd_a <= ptr_dec(rd_a);
                    rd_b <= ptr_inc(rd_b);
                    cnt  <= cnt + PW'(1);
                end
                OUT: begin
                    dout    <= dout_nxt;
                    val_out <= 1'b1;
                end
                default: ;
            endcase
            if (val_in && busy) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sec_fir_param.sv
// Directed bench for sec_fir_param: default, symmetric-folded and rounding instances share one stimulus bus.
// Expected results are hand-computed constants.
module tb_sec_fir_param;
    localparam int WIN = 16, WC = 18, N = 17, WOUT = 19, AW = 5, IDLE_LIMIT = 60;

    typedef struct {
        int din;
        int reps;
        int exp_a;
        int exp_b;
        int exp_c;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, val_in = 1'b0, coef_we = 1'b0;
    logic signed [WIN-1:0] din = '0;
    logic [AW-1:0] coef_addr = '0;
    logic signed [WC-1:0] coef_din = '0;
    logic signed [WOUT-1:0] dout_a, dout_b, dout_c;
    logic val_out_a, val_out_b, val_out_c, busy_a, busy_b, busy_c;
    logic overrun_a, overrun_b, overrun_c;

    int checks = 0, errors = 0;
    int vo_a = 0, vo_b = 0, vo_c = 0;
    int va0, vb0, vc0;
    int bc_a = 0, bc_b = 0, first_a = -1, second_a = -1, first_b = -1, second_b = -1;
    vec_t vq[$];

    int imp_a[18] = '{2048, 4096, 6144, 8192, 10240, 12288, 14336, 16384, 18432,
                      20480, 22528, 24576, 26624, 28672, 30720, 32768, 34816, 0};
    int imp_b[18] = '{2048, 4096, 6144, 8192, 10240, 12288, 14336, 16384, 18432,
                      16384, 14336, 12288, 10240, 8192, 6144, 4096, 2048, 0};

    sec_fir_param dut_a (
        .clk(clk), .rst(rst), .val_in(val_in), .din(din), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_din(coef_din), .dout(dout_a),
        .val_out(val_out_a), .busy(busy_a), .overrun(overrun_a));
    sec_fir_param #(.SYM(1)) dut_b (
        .clk(clk), .rst(rst), .val_in(val_in), .din(din), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_din(coef_din), .dout(dout_b),
        .val_out(val_out_b), .busy(busy_b), .overrun(overrun_b));
    sec_fir_param #(.RND(1)) dut_c (
        .clk(clk), .rst(rst), .val_in(val_in), .din(din), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_din(coef_din), .dout(dout_c),
        .val_out(val_out_c), .busy(busy_c), .overrun(overrun_c));

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (val_out_a) vo_a++;
        if (val_out_b) vo_b++;
        if (val_out_c) vo_c++;
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_a || busy_b || busy_c) && n < IDLE_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (busy_a || busy_b || busy_c) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still high after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic send(input logic signed [WIN-1:0] s);
        @(negedge clk);
        val_in = 1'b1;
        din    = s;
        @(negedge clk);
        val_in = 1'b0;
        wait_idle("send");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_din  = WC'(val);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_all(input int val);
        for (int i = 0; i < N; i++) write_coef(i, val);
    endtask

    task automatic load_imp();
        for (int i = 0; i < N; i++) write_coef(i, (i + 1) * 4096);
    endtask

    task automatic add(input int d, input int r, input int ea, input int eb, input int ec);
        vec_t v;
        v.din = d; v.reps = r; v.exp_a = ea; v.exp_b = eb; v.exp_c = ec;
        vq.push_back(v);
    endtask

    task automatic add_imp();
        for (int i = 0; i < 18; i++) add((i == 0) ? 16384 : 0, 1, imp_a[i], imp_b[i], imp_a[i]);
    endtask

    task automatic run_vecs(input string tag);
        int total = 0;
        int a0 = vo_a, b0 = vo_b, c0 = vo_c;
        foreach (vq[i]) begin
            for (int r = 0; r < vq[i].reps; r++) send(WIN'(vq[i].din));
            total += vq[i].reps;
            check($sformatf("%s[%0d] dout_a", tag, i), $signed(dout_a), vq[i].exp_a);
            check($sformatf("%s[%0d] dout_b", tag, i), $signed(dout_b), vq[i].exp_b);
            check($sformatf("%s[%0d] dout_c", tag, i), $signed(dout_c), vq[i].exp_c);
        end
        check({tag, " val_out_a count"}, vo_a - a0, total);
        check({tag, " val_out_b count"}, vo_b - b0, total);
        check({tag, " val_out_c count"}, vo_c - c0, total);
        vq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst dout_a", $signed(dout_a), 0);
        check("rst val_out_a", val_out_a, 0);
        check("rst busy_a", busy_a, 0);
        check("rst overrun_a", overrun_a, 0);
        check("rst busy_b", busy_b, 0);

        // Release with val_in already high; back-to-back accept while val_out is high
        val_in = 1'b1;
        din    = 16'sd500;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        val_in = 1'b0;
        for (int n = 0; n <= 45; n++) begin
            if (busy_a) bc_a++;
            if (busy_b) bc_b++;
            if (val_out_a) begin
                if (first_a < 0) first_a = n;
                else if (second_a < 0) second_a = n;
            end
            if (val_out_b) begin
                if (first_b < 0) first_b = n;
                else if (second_b < 0) second_b = n;
            end
            if (n == 18) begin
                val_in = 1'b1;
                din    = 16'sd600;
            end
            if (n == 19) val_in = 1'b0;
            @(posedge clk);
            #1;
        end
        check("lat first val_out_a", first_a, 18);
        check("lat second val_out_a", second_a, 37);
        check("lat busy_a cycles", bc_a, 36);
        check("lat first val_out_b", first_b, 10);
        check("lat second val_out_b", second_b, 29);
        check("lat busy_b cycles", bc_b, 20);
        check("lat overrun_a", overrun_a, 0);
        check("lat overrun_b", overrun_b, 0);

        // Impulse response
        do_reset();
        load_imp();
        add_imp();
        run_vecs("impulse");

        // Running-sum filter: all taps 2^15, so dout is the sum of the last 17 samples
        do_reset();
        load_all(32768);
        add(1000, 1, 1000, 1000, 1000);
        add(-3000, 1, -2000, -2000, -2000);
        add(5000, 1, 3000, 3000, 3000);
        add(32767, 1, 35767, 35767, 35767);
        add(-32768, 1, 2999, 2999, 2999);
        add(7, 1, 3006, 3006, 3006);
        add(0, 11, 3006, 3006, 3006);
        add(0, 1, 2006, 2006, 2006);
        add(0, 1, 5006, 5006, 5006);
        add(0, 1, 6, 6, 6);
        add(0, 1, -32761, -32761, -32761);
        add(0, 1, 7, 7, 7);
        add(0, 1, 0, 0, 0);
        run_vecs("window");

        // Truncation versus round-half-up
        do_reset();
        write_coef(0, 16384);
        add(1, 1, 0, 0, 1);
        add(-1, 1, -1, -1, 0);
        add(3, 1, 1, 1, 2);
        add(-3, 1, -2, -2, -1);
        run_vecs("round");

        // Overrun pulse and coefficient write while busy are both ignored
        do_reset();
        load_all(32768);
        va0 = vo_a;
        vb0 = vo_b;
        @(negedge clk);
        val_in = 1'b1;
        din    = 16'sd100;
        @(posedge clk);
        #1;
        val_in = 1'b0;
        @(posedge clk);
        #1;
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_din  = '0;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ovr overrun_a before pulse", overrun_a, 0);
        val_in = 1'b1;
        din    = 16'sd5000;
        @(posedge clk);
        #1;
        val_in = 1'b0;
        check("ovr overrun_a", overrun_a, 1);
        check("ovr overrun_b", overrun_b, 1);
        wait_idle("overrun");
        check("ovr dout_a", $signed(dout_a), 100);
        check("ovr dout_b", $signed(dout_b), 100);
        check("ovr val_out_a count", vo_a - va0, 1);
        check("ovr val_out_b count", vo_b - vb0, 1);
        send(16'sd200);
        check("ovr next dout_a", $signed(dout_a), 300);
        check("ovr next dout_b", $signed(dout_b), 300);
        check("ovr next dout_c", $signed(dout_c), 300);
        check("ovr sticky overrun_a", overrun_a, 1);

        // Saturation at both rails
        do_reset();
        load_all(-131072);
        add(-32768, 17, 262143, 262143, 262143);
        run_vecs("sat_pos");
        do_reset();
        load_all(131071);
        add(-32768, 17, -262144, -262144, -262144);
        run_vecs("sat_neg");

        // Reset during MAC cycle 7 aborts the computation
        load_imp();
        va0 = vo_a;
        vb0 = vo_b;
        vc0 = vo_c;
        @(negedge clk);
        val_in = 1'b1;
        din    = 16'sd16384;
        @(posedge clk);
        #1;
        val_in = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst busy_a", busy_a, 0);
        check("midrst dout_a", $signed(dout_a), 0);
        check("midrst val_out_a", val_out_a, 0);
        check("midrst busy_b", busy_b, 0);
        check("midrst dout_b", $signed(dout_b), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst val_out_a count", vo_a - va0, 0);
        check("midrst val_out_b count", vo_b - vb0, 0);
        check("midrst val_out_c count", vo_c - vc0, 0);
        check("midrst dout_a held", $signed(dout_a), 0);
        load_imp();
        add_imp();
        run_vecs("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
